// File: rtl/load_resp_pipe.sv
// load_resp_pipe: configurable-depth valid/ready register pipe between the
// data-cache load response and load writeback, with flush and occupancy count.
module load_resp_pipe #(
    parameter int NR_STAGES  = 1,
    parameter int XLEN       = 64,
    parameter int TRANS_ID_W = 3,
    localparam int OW        = NR_STAGES > 0 ? $clog2(NR_STAGES + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [XLEN-1:0]       in_data_i,
    input  logic [TRANS_ID_W-1:0] in_trans_id_i,
    input  logic                  in_ex_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [XLEN-1:0]       out_data_o,
    output logic [TRANS_ID_W-1:0] out_trans_id_o,
    output logic                  out_ex_o,
    output logic [OW-1:0]         occupancy_o
);
    if (NR_STAGES == 0) begin : g_bypass
        assign out_valid_o    = in_valid_i & ~flush_i;
        assign in_ready_o     = out_ready_i | flush_i;
        assign out_data_o     = in_data_i;
        assign out_trans_id_o = in_trans_id_i;
        assign out_ex_o       = in_ex_i;
        assign occupancy_o    = '0;
    end else begin : g_pipe
        logic [NR_STAGES-1:0]  valid_q, valid_d, ex_q, ex_d;
        logic [XLEN-1:0]       data_q [NR_STAGES];
        logic [XLEN-1:0]       data_d [NR_STAGES];
        logic [TRANS_ID_W-1:0] id_q [NR_STAGES];
        logic [TRANS_ID_W-1:0] id_d [NR_STAGES];
        logic [NR_STAGES:0]    up_v, up_ex, rdy;
        logic [XLEN-1:0]       up_d [NR_STAGES+1];
        logic [TRANS_ID_W-1:0] up_id [NR_STAGES+1];
        logic [OW-1:0]         occ_q, occ_d;
        logic                  in_acc, out_acc;
        // Index k+1 of the up_* arrays is what feeds stage k+1; index 0 is the input port.
        always_comb begin
            up_v     = {valid_q, in_valid_i};
            up_ex    = {ex_q, in_ex_i};
            up_d[0]  = in_data_i;
            up_id[0] = in_trans_id_i;
            for (int k = 0; k < NR_STAGES; k++) begin
                up_d[k+1]  = data_q[k];
                up_id[k+1] = id_q[k];
            end
            rdy = {out_ready_i, {NR_STAGES{1'b0}}};
            for (int k = NR_STAGES - 1; k >= 0; k--) rdy[k] = ~valid_q[k] | rdy[k+1];
            valid_d = '0;
            ex_d    = ex_q;
            data_d  = data_q;
            id_d    = id_q;
            for (int k = 0; k < NR_STAGES; k++) begin
                valid_d[k] = ~flush_i & (rdy[k] ? up_v[k] : valid_q[k]);
                ex_d[k]    = (rdy[k] & up_v[k]) ? up_ex[k] : ex_q[k];
                data_d[k]  = (rdy[k] & up_v[k]) ? up_d[k] : data_q[k];
                id_d[k]    = (rdy[k] & up_v[k]) ? up_id[k] : id_q[k];
            end
            in_acc  = in_valid_i & rdy[0] & ~flush_i;
            out_acc = valid_q[NR_STAGES-1] & out_ready_i;
            occ_d   = flush_i ? '0 : occ_q + OW'(in_acc) - OW'(out_acc);
        end
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                valid_q <= '0;
                ex_q    <= '0;
                data_q  <= '{default: '0};
                id_q    <= '{default: '0};
                occ_q   <= '0;
            end else begin
                valid_q <= valid_d;
                ex_q    <= ex_d;
                data_q  <= data_d;
                id_q    <= id_d;
                occ_q   <= occ_d;
            end
        end
        always_ff @(posedge clk_i) begin
            if (rst_ni) assert ($countones(valid_q) == int'(occ_q));
        end
        assign in_ready_o     = rdy[0] | flush_i;
        assign out_valid_o    = valid_q[NR_STAGES-1];
        assign out_data_o     = data_q[NR_STAGES-1];
        assign out_trans_id_o = id_q[NR_STAGES-1];
        assign out_ex_o       = ex_q[NR_STAGES-1];
        assign occupancy_o    = occ_q;
    end
endmodule

// File: tb/tb_load_resp_pipe.sv
// tb_load_resp_pipe: drives shared stimulus into 0-, 1- and 2-stage pipes and
// checks each against a queue model of in-flight responses.
module tb_load_resp_pipe;
    localparam int XL = 64;
    localparam int TW = 3;

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic          in_valid = 1'b0, in_ex = 1'b0, out_ready = 1'b0;
    logic [XL-1:0] in_data = '0;
    logic [TW-1:0] in_id = '0;
    int            checks = 0, errs = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // An entry reaches the output no earlier than NR_STAGES edges after entry
    // and no earlier than the edge on which the entry ahead of it departed.
    for (genvar g = 0; g < 2; g++) begin : g_p
        localparam int N  = g + 1;
        localparam int OW = $clog2(N + 1);
        typedef struct packed {
            logic [XL-1:0] d;
            logic [TW-1:0] id;
            logic          ex;
            int            enter;
        } ent_t;
        logic          in_ready, out_valid, out_ex;
        logic [XL-1:0] out_data;
        logic [TW-1:0] out_id;
        logic [OW-1:0] occ;
        ent_t          q[$];
        int            t = 0, last_dep = -100;

        load_resp_pipe #(.NR_STAGES(N), .XLEN(XL), .TRANS_ID_W(TW)) dut (
            .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
            .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
            .in_trans_id_i(in_id), .in_ex_i(in_ex),
            .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
            .out_trans_id_o(out_id), .out_ex_o(out_ex), .occupancy_o(occ)
        );

        function automatic bit head_vis();
            return q.size() > 0 && t >= q[0].enter + N - 1 && t >= last_dep;
        endfunction

        always @(posedge clk) begin
            bit vis, in_acc, out_acc;
            vis     = head_vis();
            in_acc  = in_valid && (q.size() < N || out_ready);
            out_acc = vis && out_ready;
            t++;
            if (!rst_n || flush) q.delete();
            else begin
                if (out_acc) begin
                    void'(q.pop_front());
                    last_dep = t;
                end
                if (in_acc) q.push_back('{in_data, in_id, in_ex, t});
            end
        end

        always @(negedge clk) begin
            bit vis;
            vis = head_vis();
            chk($sformatf("n%0d occupancy", N), 64'(occ), 64'(q.size()));
            chk($sformatf("n%0d in_ready", N), 64'(in_ready), 64'(flush || q.size() < N || out_ready));
            chk($sformatf("n%0d out_valid", N), 64'(out_valid), 64'(vis));
            if (vis) begin
                chk($sformatf("n%0d out_data", N), out_data, q[0].d);
                chk($sformatf("n%0d out_id", N), 64'(out_id), 64'(q[0].id));
                chk($sformatf("n%0d out_ex", N), 64'(out_ex), 64'(q[0].ex));
            end
        end
    end

    logic          z_ready, z_valid, z_ex;
    logic [XL-1:0] z_data;
    logic [TW-1:0] z_id;
    logic [0:0]    z_occ;

    load_resp_pipe #(.NR_STAGES(0), .XLEN(XL), .TRANS_ID_W(TW)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(z_ready), .in_data_i(in_data),
        .in_trans_id_i(in_id), .in_ex_i(in_ex),
        .out_valid_o(z_valid), .out_ready_i(out_ready), .out_data_o(z_data),
        .out_trans_id_o(z_id), .out_ex_o(z_ex), .occupancy_o(z_occ)
    );

    always @(negedge clk) begin
        chk("n0 out_valid", 64'(z_valid), 64'(in_valid && !flush));
        chk("n0 in_ready", 64'(z_ready), 64'(out_ready || flush));
        chk("n0 out_data", z_data, in_data);
        chk("n0 out_id", 64'(z_id), 64'(in_id));
        chk("n0 out_ex", 64'(z_ex), 64'(in_ex));
        chk("n0 occupancy", 64'(z_occ), 64'(0));
    end

    task automatic drive(input logic v, input logic [XL-1:0] d, input logic [TW-1:0] id,
                         input logic ex, input logic ordy, input logic fl, input logic rn);
        in_valid  = v;
        in_data   = d;
        in_id     = id;
        in_ex     = ex;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) drive(0, '0, '0, 0, 1, 0, 0);
        drive(0, '0, '0, 0, 1, 0, 1);
        drive(1, 64'hDEADBEEF_00000001, 3'd5, 0, 1, 0, 1);
        repeat (3) drive(0, '0, '0, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++) drive(1, {32'hA5A5_0000, 32'(i)}, TW'(i), i[0], 1, 0, 1);
        repeat (3) drive(0, '0, '0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 64'h1000 + 64'(i), TW'(i), 0, 0, 0, 1);
        drive(0, '0, '0, 0, 0, 0, 1);
        drive(1, 64'h1002, 3'd2, 0, 1, 0, 1);
        repeat (4) drive(0, '0, '0, 0, 1, 0, 1);
        drive(1, 64'h2000, 3'd1, 0, 0, 0, 1);
        drive(1, 64'h2001, 3'd2, 1, 0, 0, 1);
        drive(1, 64'h2002, 3'd3, 0, 0, 1, 1);
        repeat (2) drive(0, '0, '0, 0, 1, 0, 1);
        drive(1, 64'h3000, 3'd4, 0, 0, 0, 1);
        drive(0, '0, '0, 0, 0, 0, 0);
        drive(1, 64'h3001, 3'd6, 1, 1, 0, 1);
        repeat (3) drive(0, '0, '0, 0, 1, 0, 1);
        repeat (3000)
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, TW'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 80) != 0);
        repeat (4) drive(0, '0, '0, 0, 1, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
